// File: rtl/servo_pwm_pkg.sv
// Shared types and 100 MHz servo timing constants for the servo PWM generator.
package servo_pwm_pkg;

   localparam int SERVO_CNT_W = 21;

   typedef logic [SERVO_CNT_W-1:0] duty_t;

   // 20 ms frame, 1.0 ms .. 2.0 ms pulse, 1.5 ms neutral at 100 MHz
   localparam int SERVO_PERIOD   = 2000000;
   localparam int SERVO_MIN_DUTY = 100000;
   localparam int SERVO_MAX_DUTY = 200000;
   localparam int SERVO_RST_DUTY = 150000;
   localparam int SERVO_STEP     = 1000;

endpackage

// File: rtl/servo_pwm_ramp.sv
// Combinational slew limiter: moves active toward target by at most STEP, never overshooting.
module servo_pwm_ramp
   import servo_pwm_pkg::*;
#(
   parameter int CNT_W = SERVO_CNT_W,
   parameter int STEP  = SERVO_STEP
) (
   input  logic [CNT_W-1:0] active,
   input  logic [CNT_W-1:0] target,
   output logic [CNT_W-1:0] next_active
);

   localparam logic signed [CNT_W:0] STEP_S = (CNT_W+1)'(STEP);

   logic signed [CNT_W:0] act_s;
   logic signed [CNT_W:0] tgt_s;
   logic signed [CNT_W:0] diff_s;
   logic signed [CNT_W:0] sum_s;

   // One extra bit keeps the difference signed without wrapping
   always_comb begin
      act_s  = signed'({1'b0, active});
      tgt_s  = signed'({1'b0, target});
      diff_s = tgt_s - act_s;
      if (diff_s > STEP_S) begin
         sum_s = act_s + STEP_S;
      end else if (diff_s < -STEP_S) begin
         sum_s = act_s - STEP_S;
      end else begin
         sum_s = tgt_s;
      end
      next_active = CNT_W'(sum_s);
   end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator with clamped, period-aligned duty updates.
// Optional slew limiting is compiled in with SERVO_PWM_RAMP_EN.
module servo_pwm_gen
   import servo_pwm_pkg::*;
#(
   parameter int CNT_W    = SERVO_CNT_W,
   parameter int PERIOD   = SERVO_PERIOD,
   parameter int MIN_DUTY = SERVO_MIN_DUTY,
   parameter int MAX_DUTY = SERVO_MAX_DUTY,
   parameter int RST_DUTY = SERVO_RST_DUTY,
   parameter int STEP     = SERVO_STEP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] duty_i,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_o,
   output logic             period_tick,
   output logic             busy
);

   if (!(MIN_DUTY <= RST_DUTY && RST_DUTY <= MAX_DUTY && MAX_DUTY <= PERIOD &&
         STEP >= 1 && PERIOD >= 2)) begin : g_bad_cfg
      $error("servo_pwm_gen: inconsistent PERIOD/duty/STEP parameters");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] MIN_D    = CNT_W'(MIN_DUTY);
   localparam logic [CNT_W-1:0] MAX_D    = CNT_W'(MAX_DUTY);
   localparam logic [CNT_W-1:0] RST_D    = CNT_W'(RST_DUTY);

   function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
      logic [CNT_W-1:0] r;
      r = d;
      if (d < MIN_D) begin
         r = MIN_D;
      end else if (d > MAX_D) begin
         r = MAX_D;
      end
      return r;
   endfunction

   logic [CNT_W-1:0] cnt_p0;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] pend_p0;
   logic [CNT_W-1:0] target_p0;
   logic [CNT_W-1:0] active_p0;
   logic [CNT_W-1:0] active_nxt;
   logic             pend_vld_p0;
   logic             tick_p0;
   logic             pwm_p1;
   logic             boundary;
   logic             accept;

   assign boundary = (cnt_p0 == LAST_CNT);
   assign cnt_nxt  = boundary ? '0 : cnt_p0 + CNT_W'(1);
   assign accept   = duty_valid & ~pend_vld_p0;

`ifdef SERVO_PWM_RAMP_EN
   // Ramp from the target held before this boundary's transfer
   servo_pwm_ramp #(
      .CNT_W (CNT_W),
      .STEP  (STEP)
   ) u_ramp (
      .active      (active_p0),
      .target      (target_p0),
      .next_active (active_nxt)
   );
`else
   assign active_nxt = pend_vld_p0 ? pend_p0 : active_p0;
`endif

   // Stage 0: counter, pending slot, target/active; stage 1: registered PWM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0      <= '0;
         tick_p0     <= 1'b0;
         pend_vld_p0 <= 1'b0;
         pend_p0     <= RST_D;
         target_p0   <= RST_D;
         active_p0   <= RST_D;
         pwm_p1      <= 1'b0;
      end else begin
         cnt_p0  <= cnt_nxt;
         tick_p0 <= (cnt_nxt == LAST_CNT);
         pwm_p1  <= (cnt_p0 < active_p0);
         if (boundary && pend_vld_p0) begin
            pend_vld_p0 <= 1'b0;
            target_p0   <= pend_p0;
         end else if (accept) begin
            pend_vld_p0 <= 1'b1;
            pend_p0     <= clamp_duty(duty_i);
         end
         if (boundary) begin
            active_p0 <= active_nxt;
         end
      end
   end

   assign duty_ready  = ~pend_vld_p0;
   assign pwm_o       = pwm_p1;
   assign period_tick = tick_p0;
   assign busy        = pend_vld_p0 | (active_p0 != target_p0);

endmodule
